// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-pin output stage; each pin is forced low, static high, or the shared PWM level.
// Optional macro PWM_SHADOW_UPDATE_EN latches enables and duty only at the PWM period wrap.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_r;
  logic [7:0]       cnt_r;
  logic [7:0]       cnt_next_s;
  logic             tick_s;
  logic             wrap_s;
  logic             pwm_lvl_s;
  logic [15:0]      en_out_s;
  logic [15:0]      en_pwm_s;
  logic [7:0]       duty_s;
  logic [15:0]      out_next_s;

  assign tick_s = (pre_r == PRE_LAST);
  assign wrap_s = tick_s && (cnt_r == 8'hFF);

`ifdef PWM_SHADOW_UPDATE_EN
  logic [15:0] en_out_r;
  logic [15:0] en_pwm_r;
  logic [7:0]  duty_r;

  // Shadow copies refresh only on the wrap edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_r <= 16'h0000;
      en_pwm_r <= 16'h0000;
      duty_r   <= 8'h00;
    end else if (wrap_s) begin
      en_out_r <= {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_r <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
      duty_r   <= pwm_duty_cycle;
    end
  end

  // On the wrap edge the first compare of the new period already uses the incoming values
  always_comb begin
    if (wrap_s) begin
      en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      duty_s   = pwm_duty_cycle;
    end else begin
      en_out_s = en_out_r;
      en_pwm_s = en_pwm_r;
      duty_s   = duty_r;
    end
  end
`else
  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign duty_s   = pwm_duty_cycle;
`endif

  // Prescaler: counts 0..PRESCALE-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
    end else if (tick_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // Next counter value and shared PWM level; out is compared against the value cnt takes on this edge
  always_comb begin
    cnt_next_s = cnt_r;
    if (tick_s) begin
      cnt_next_s = cnt_r + 8'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
    if (duty_s == 8'hFF) begin
      pwm_lvl_s = 1'b1;
    end else begin
      pwm_lvl_s = (cnt_next_s < duty_s);
    end
  end

  // Per-pin output select
  always_comb begin
    out_next_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (!en_out_s[i]) begin
        out_next_s[i] = 1'b0;
      end else if (!en_pwm_s[i]) begin
        out_next_s[i] = 1'b1;
      end else begin
        out_next_s[i] = pwm_lvl_s;
      end
    end
  end

  // Counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= 8'h00;
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      out          <= out_next_s;
      period_start <= wrap_s;
    end
  end

endmodule
